mem_bus_arbiter: RTL and testbench

- Shares the CPU's single memory port between instruction fetch (IF) and data memory (DM) requesters.
- Sits between the LEGv8 datapath fetch/load-store logic and the unified memory.
- Serialises one transaction at a time through a fixed-latency memory using a request/done handshake.
- DM has priority; a starvation guard forces an IF grant after a bounded DM streak.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_grant.sv | 44 ++++
 rtl/mem_bus_arbiter.sv | 118 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory bus arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  localparam int ALIGN_W = 3;

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - DM-priority grant decision with IF starvation guard
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int MAX_DM_STREAK = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sample,
  input  logic if_req,
  input  logic dm_req,
  output logic grant,
  output logic grant_owner
);

  localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  logic [STREAK_W-1:0] streak;

  always_comb begin
    grant       = sample && (if_req || dm_req);
    grant_owner = OWNER_IF;
    if (dm_req && !(if_req && (streak == STREAK_MAX))) begin
      grant_owner = OWNER_DM;
    end
  end

  // Only contested DM grants build the streak; anything else resets it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else if (grant) begin
      if ((grant_owner == OWNER_DM) && if_req) begin
        if (streak != STREAK_MAX) begin
          streak <= streak + 1'b1;
        end
      end else begin
        streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - serialises IF and DM requests onto one fixed-latency memory port
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 64,
  parameter int INSTR_W       = 32,
  parameter int MEM_LATENCY   = 2,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic [INSTR_W-1:0] if_rdata,
  output logic               if_done,
  input  logic               dm_req,
  input  logic               dm_we,
  input  logic [ADDR_W-1:0]  dm_addr,
  input  logic [DATA_W-1:0]  dm_wdata,
  output logic [DATA_W-1:0]  dm_rdata,
  output logic               dm_done,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               owner,
  output logic               busy
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  arb_state_t         state, state_next;
  logic [CNT_W-1:0]   count;
  logic [ADDR_W-1:0]  lat_addr;
  logic               lat_we;
  logic [DATA_W-1:0]  lat_wdata;
  logic               grant;
  logic               grant_owner;
  logic               unused_lat_bits;

  mem_arb_grant #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) u_grant (
    .clock      (clock),
    .reset      (reset),
    .sample     (state == IDLE),
    .if_req     (if_req),
    .dm_req     (dm_req),
    .grant      (grant),
    .grant_owner(grant_owner)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = ACCESS;
      ACCESS:  if (count == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      owner     <= OWNER_IF;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (grant) begin
            owner <= grant_owner;
            count <= CNT_INIT;
            if (grant_owner == OWNER_DM) begin
              lat_addr  <= dm_addr;
              lat_we    <= dm_we;
              lat_wdata <= dm_wdata;
            end else begin
              lat_addr  <= if_addr;
              lat_we    <= 1'b0;
              lat_wdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (count != '0) begin
            count <= count - 1'b1;
          end else if (owner == OWNER_DM) begin
            if (!lat_we) dm_rdata <= mem_rdata;
          end else begin
            if_rdata <= lat_addr[2] ? mem_rdata[DATA_W-1:INSTR_W] : mem_rdata[INSTR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so reset kills them without waiting for an edge.
  assign mem_en          = (state == ACCESS);
  assign mem_we          = mem_en && lat_we;
  assign mem_addr        = {lat_addr[ADDR_W-1:ALIGN_W], ALIGN_W'(0)};
  assign mem_wdata       = lat_wdata;
  assign if_done         = (state == DONE) && (owner == OWNER_IF);
  assign dm_done         = (state == DONE) && (owner == OWNER_DM);
  assign busy            = (state != IDLE);
  assign unused_lat_bits = ^lat_addr[1:0];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;

  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr;
  logic [63:0] dm_wdata, mem_rdata;
  logic [31:0] if_rdata;
  logic [63:0] dm_rdata, mem_wdata;
  logic [31:0] mem_addr;
  logic        if_done, dm_done, mem_en, mem_we, owner, busy;

  logic        if_req1, dm_req1, dm_we1;
  logic [31:0] if_addr1, dm_addr1;
  logic [63:0] dm_wdata1, mem_rdata1;
  logic [31:0] if_rdata1;
  logic [63:0] dm_rdata1, mem_wdata1;
  logic [31:0] mem_addr1;
  logic        if_done1, dm_done1, mem_en1, mem_we1, owner1, busy1;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter u_dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  mem_bus_arbiter #(.MEM_LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_done(if_done1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_done(dm_done1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .owner(owner1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (if_done || dm_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit   seen;
    logic exp_owner [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    if_req = 0; dm_req = 0; dm_we = 0; if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    if_req1 = 0; dm_req1 = 0; dm_we1 = 0; if_addr1 = '0; dm_addr1 = '0; dm_wdata1 = '0; mem_rdata1 = '0;
    tick(); tick();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_dones", {if_done, dm_done}, 0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 0);
    chk("rst_owner_busy", {owner, busy}, 0);
    reset = 1'b0;
    tick();

    // IF-only fetch from an upper word
    mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD; if_addr = 32'h104; if_req = 1;
    tick();
    chk("if_acc1_en", mem_en, 1);
    chk("if_acc1_addr", mem_addr, 32'h100);
    chk("if_acc1_we", mem_we, 0);
    chk("if_acc1_owner_busy", {owner, busy}, 2'b01);
    chk("if_acc1_done", if_done, 0);
    tick();
    chk("if_acc2_en", mem_en, 1);
    chk("if_acc2_done", if_done, 0);
    tick();
    chk("if_done_t3", {if_done, dm_done}, 2'b10);
    chk("if_done_en", mem_en, 0);
    chk("if_rdata", if_rdata, 32'hAAAA_BBBB);
    if_req = 0;
    tick();
    chk("if_idle_busy", busy, 0);

    // DM store
    mem_rdata = 64'hFFFF_0000_FFFF_0000;
    dm_req = 1; dm_we = 1; dm_addr = 32'h208; dm_wdata = 64'h1122_3344_5566_7788;
    tick();
    chk("st_acc1_we", {mem_en, mem_we}, 2'b11);
    chk("st_acc1_addr", mem_addr, 32'h208);
    chk("st_acc1_wdata", mem_wdata, 64'h1122_3344_5566_7788);
    chk("st_acc1_owner", owner, 1);
    tick();
    chk("st_acc2_we", {mem_en, mem_we}, 2'b11);
    tick();
    chk("st_done_t3", {if_done, dm_done}, 2'b01);
    chk("st_dm_rdata", dm_rdata, 0);
    chk("st_if_rdata_hold", if_rdata, 32'hAAAA_BBBB);
    chk("st_done_we", mem_we, 0);
    dm_req = 0; dm_we = 0;
    tick();

    // Both requesting continuously: four DM grants, then a forced IF
    mem_rdata = 64'h5555_6666_7777_8888; if_addr = 32'h0; dm_addr = 32'h400;
    if_req = 1; dm_req = 1;
    for (int i = 0; i < 6; i++) begin
      wait_done(seen);
      chk($sformatf("sim_seen_%0d", i), seen, 1);
      chk($sformatf("sim_owner_%0d", i), owner, exp_owner[i]);
      chk($sformatf("sim_done_%0d", i), {if_done, dm_done}, exp_owner[i] ? 2'b01 : 2'b10);
    end
    if_req = 0; dm_req = 0;
    tick();

    // DM request raised mid-fetch is served after the next IDLE
    mem_rdata = 64'h0123_4567_89AB_CDEF; if_addr = 32'h8; if_req = 1;
    tick();
    tick();
    dm_req = 1; dm_we = 0; dm_addr = 32'h30F;
    tick();
    chk("hb_if_done", {if_done, dm_done}, 2'b10);
    chk("hb_if_rdata", if_rdata, 32'h89AB_CDEF);
    if_req = 0;
    tick();
    chk("hb_idle", {busy, if_done, dm_done}, 0);
    tick();
    chk("hb_dm_grant", {owner, mem_en}, 2'b11);
    chk("hb_dm_addr", mem_addr, 32'h308);
    tick();
    chk("hb_dm_acc2", {if_done, dm_done}, 0);
    tick();
    chk("hb_dm_done", {if_done, dm_done}, 2'b01);
    chk("hb_dm_rdata", dm_rdata, 64'h0123_4567_89AB_CDEF);
    dm_req = 0;
    tick();
    chk("hb_no_dup", {if_done, dm_done}, 0);

    // Reset in the middle of an access
    if_addr = 32'h10; if_req = 1;
    tick();
    chk("rm_pre_en", mem_en, 1);
    #2 reset = 1'b1;
    #1;
    chk("rm_async_en", {mem_en, mem_we}, 0);
    chk("rm_busy_owner", {busy, owner}, 0);
    chk("rm_rdata", {if_rdata, dm_rdata}, 0);
    chk("rm_addr", mem_addr, 0);
    if_req = 0;
    tick();
    chk("rm_no_done", {if_done, dm_done}, 0);
    reset = 1'b0;
    tick();
    mem_rdata = 64'hCAFE_F00D_1234_5678; if_addr = 32'h14; if_req = 1;
    tick();
    tick();
    tick();
    chk("rm_fresh_done", {if_done, dm_done}, 2'b10);
    chk("rm_fresh_rdata", if_rdata, 32'hCAFE_F00D);
    if_req = 0;
    tick();

    // Single-cycle latency build: DM load from 0
    mem_rdata1 = 64'hDEAD_DEAD_DEAD_DEAD; dm_addr1 = 32'h0; dm_we1 = 0; dm_req1 = 1;
    tick();
    chk("l1_acc_en", mem_en1, 1);
    chk("l1_acc_addr", mem_addr1, 0);
    chk("l1_acc_done", dm_done1, 0);
    mem_rdata1 = 64'h0F1E_2D3C_4B5A_6978;
    tick();
    chk("l1_done_t2", {if_done1, dm_done1}, 2'b01);
    chk("l1_rdata", dm_rdata1, 64'h0F1E_2D3C_4B5A_6978);
    chk("l1_done_en", mem_en1, 0);
    dm_req1 = 0;
    tick();
    chk("l1_idle", {busy1, dm_done1}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
